// File: rtl/uart_cmd_link_pkg.sv
// Shared definitions for the UART command link: response modes, default
// response codes, FSM state encoding and the FIFO entry layout.
package uart_cmd_link_pkg;

  localparam int MODE_ECHO    = 0;
  localparam int MODE_ACK     = 1;
  localparam int MODE_DECODED = 2;

  localparam logic [7:0] DEF_ACK_BYTE  = 8'h3C;
  localparam logic [7:0] DEF_NACK_BYTE = 8'hC3;

  // Cycles spent waiting for uart_tx to go busy before the request is abandoned
  localparam int BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } link_state_t;

  typedef struct packed {
    logic       bad;
    logic [7:0] dec;
    logic [7:0] raw;
  } fifo_entry_t;

endpackage

// File: rtl/uart_cmd_link_hamm74.sv
// Combinational SECDED decoder for Hamming(7,4) with an overall parity bit in b7.
// Bit layout: b0=p1 b1=p2 b2=d0 b3=p3 b4=d1 b5=d2 b6=d3 b7=overall parity.
module hamm74_secded_dec (
  input  logic [7:0] in,
  output logic [3:0] nibble,
  output logic       corrected,
  output logic       double_err
);

  logic [2:0] w_syn;
  logic       w_par;

  assign w_syn = {in[3] ^ in[4] ^ in[5] ^ in[6],
                  in[1] ^ in[2] ^ in[5] ^ in[6],
                  in[0] ^ in[2] ^ in[4] ^ in[6]};
  assign w_par = ^in;

  // A non-zero syndrome with odd overall parity is a single error at position syn
  assign corrected  = (w_syn != 3'd0) &  w_par;
  assign double_err = (w_syn != 3'd0) & ~w_par;

  assign nibble = {in[6] ^ (corrected & (w_syn == 3'd7)),
                   in[5] ^ (corrected & (w_syn == 3'd6)),
                   in[4] ^ (corrected & (w_syn == 3'd5)),
                   in[2] ^ (corrected & (w_syn == 3'd3))};

endmodule

// File: rtl/uart_cmd_link.sv
// Protocol layer between uart_rx and uart_tx: decodes received bytes, queues them,
// emits good commands and sends exactly one response byte per queued byte.
module uart_cmd_link
  import uart_cmd_link_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter int         MODE      = MODE_ECHO,
  parameter int         HAMMING   = 1,
  parameter logic [7:0] ACK_BYTE  = DEF_ACK_BYTE,
  parameter logic [7:0] NACK_BYTE = DEF_NACK_BYTE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_done,
  input  logic                       rx_parity_error,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       cmd_valid,
  output logic [7:0]                 cmd_byte,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [15:0]                err_count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW + 1)'(DEPTH);

  logic [3:0]  w_nibble;
  logic        w_unused_corrected;
  logic        w_double;
  logic        w_bad;
  logic [7:0]  w_dec;
  fifo_entry_t w_entry;
  fifo_entry_t w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;

  fifo_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  logic [15:0]   r_err;
  link_state_t   r_state;
  logic [1:0]    r_wait_cnt;

  hamm74_secded_dec u_dec (
    .in         (rx_data),
    .nibble     (w_nibble),
    .corrected  (w_unused_corrected),
    .double_err (w_double)
  );

  assign w_bad   = rx_parity_error | ((HAMMING != 0) & w_double);
  assign w_dec   = (HAMMING != 0) ? {4'h0, w_nibble} : rx_data;
  assign w_entry = '{bad: w_bad, dec: w_dec, raw: rx_data};
  assign w_head  = r_mem[r_rd_ptr];

  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  // A pop frees a slot in the same edge, so a full FIFO still accepts a push then
  assign w_pop   = (r_state == ST_IDLE) & ~w_empty;
  assign w_push  = rx_done & (~w_full | w_pop);

  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign err_count  = r_err;

  function automatic logic [7:0] f_response(input fifo_entry_t e);
    if (MODE == MODE_ECHO)     return e.raw;
    else if (MODE == MODE_ACK) return e.bad ? NACK_BYTE : ACK_BYTE;
    else                       return e.bad ? NACK_BYTE : e.dec;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_err      <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if (rx_done && !w_push) r_overflow <= 1'b1;
      // Dropped bytes still count as errors when bad
      if (rx_done && w_bad && (r_err != 16'hFFFF)) r_err <= r_err + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
    end else begin
      tx_start  <= 1'b0;
      cmd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            tx_start <= 1'b1;
            tx_data  <= f_response(w_head);
            if (!w_head.bad) begin
              cmd_valid <= 1'b1;
              cmd_byte  <= w_head.dec;
            end
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A request uart_tx never acknowledges is dropped, not retried
          if (tx_busy)                                    r_state <= ST_WAIT_DONE;
          else if (r_wait_cnt == 2'(BUSY_TIMEOUT - 1))    r_state <= ST_IDLE;
          else                                            r_wait_cnt <= r_wait_cnt + 2'd1;
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Bench for uart_cmd_link: three instances (echo/raw, ACK with SECDED and DEPTH 4,
// decoded echo) share rx stimulus and are checked against a queue-based model.
module tb_uart_cmd_link;
  import uart_cmd_link_pkg::*;

  localparam int N   = 3;
  localparam int LEN = 3;

  typedef struct packed {
    logic       bad;
    logic [7:0] resp;
    logic [7:0] cmd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset    = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_done  = 1'b0;
  logic       rx_perr  = 1'b0;
  logic       force_hi = 1'b0;
  logic       no_resp  = 1'b0;

  logic [N-1:0][7:0]  tx_data;
  logic [N-1:0]       tx_start;
  logic [N-1:0]       tx_busy;
  logic [N-1:0]       cmd_valid;
  logic [N-1:0][7:0]  cmd_byte;
  logic [N-1:0][3:0]  lvl;
  logic [N-1:0]       ovf;
  logic [N-1:0][15:0] errc;

  int checks = 0;
  int errors = 0;

  exp_t       q[N][$];
  logic [7:0] m_tx[N];
  logic [7:0] m_cmd[N];
  logic       m_ovf[N];
  logic [15:0] m_err[N];
  int         n_starts[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D  = (g == 1) ? 4 : 8;
    localparam int LW = $clog2(D) + 1;
    logic [LW-1:0] w_lvl;
    int cnt = 0;

    uart_cmd_link #(
      .DEPTH(D), .MODE(g), .HAMMING((g == 0) ? 0 : 1),
      .ACK_BYTE(8'h3C), .NACK_BYTE(8'hC3)
    ) u_dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .rx_parity_error(rx_perr), .tx_data(tx_data[g]), .tx_start(tx_start[g]),
      .tx_busy(tx_busy[g]), .cmd_valid(cmd_valid[g]), .cmd_byte(cmd_byte[g]),
      .fifo_level(w_lvl), .overflow(ovf[g]), .err_count(errc[g])
    );

    assign lvl[g] = 4'(w_lvl);

    // uart_tx stand-in: busy for LEN cycles starting one cycle after tx_start
    always @(posedge clk) begin
      if (reset)                           cnt <= 0;
      else if (tx_start[g] && !no_resp)    cnt <= LEN;
      else if (cnt > 0)                    cnt <= cnt - 1;
    end
    assign tx_busy[g] = force_hi | (cnt != 0);
  end

  function automatic int depth_of(input int k);
    return (k == 1) ? 4 : 8;
  endfunction

  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [7:0] c;
    c[2] = n[0]; c[4] = n[1]; c[5] = n[2]; c[6] = n[3];
    c[0] = n[0] ^ n[1] ^ n[3];
    c[1] = n[0] ^ n[2] ^ n[3];
    c[3] = n[1] ^ n[2] ^ n[3];
    c[7] = ^c[6:0];
    return c;
  endfunction

  // Nearest-codeword decode: within distance 1 of a codeword is good, else bad
  function automatic exp_t exp_of(input int mode, input int ham, input logic [7:0] b, input logic pe);
    exp_t e;
    int found;
    found = -1;
    for (int n = 0; n < 16; n++)
      if ($countones(enc(4'(n)) ^ b) <= 1) found = n;
    if (ham != 0) begin
      e.bad = pe || (found < 0);
      e.cmd = (found < 0) ? 8'h00 : {4'h0, 4'(found)};
    end else begin
      e.bad = pe;
      e.cmd = b;
    end
    if (mode == 0)      e.resp = b;
    else if (mode == 1) e.resp = e.bad ? 8'hC3 : 8'h3C;
    else                e.resp = e.bad ? 8'hC3 : e.cmd;
    return e;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string nm);
    for (int k = 0; k < N; k++) begin
      chk({nm, "_tx_start"}, k, 32'(tx_start[k]), 32'd0);
      chk({nm, "_tx_data"}, k, 32'(tx_data[k]), 32'd0);
      chk({nm, "_cmd_valid"}, k, 32'(cmd_valid[k]), 32'd0);
      chk({nm, "_cmd_byte"}, k, 32'(cmd_byte[k]), 32'd0);
      chk({nm, "_level"}, k, 32'(lvl[k]), 32'd0);
      chk({nm, "_overflow"}, k, 32'(ovf[k]), 32'd0);
      chk({nm, "_err_count"}, k, 32'(errc[k]), 32'd0);
    end
  endtask

  // Advance one clock and compare every output of every instance with the model
  task automatic tick();
    logic r, d, p;
    logic [7:0] b;
    exp_t e;
    r = reset; d = rx_done; p = rx_perr; b = rx_data;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (r || reset) begin
        q[k].delete();
        m_tx[k] = 8'h00; m_cmd[k] = 8'h00; m_ovf[k] = 1'b0; m_err[k] = 16'h0;
        chk("rst_tx_start", k, 32'(tx_start[k]), 32'd0);
        chk("rst_level", k, 32'(lvl[k]), 32'd0);
        chk("rst_err_count", k, 32'(errc[k]), 32'd0);
        chk("rst_tx_data", k, 32'(tx_data[k]), 32'd0);
        continue;
      end
      if (tx_start[k]) begin
        n_starts[k]++;
        if (q[k].size() == 0) begin
          chk("spurious_start", k, 32'(q[k].size()), 32'd1);
          chk("cmd_valid_idle", k, 32'(cmd_valid[k]), 32'd0);
        end else begin
          e = q[k].pop_front();
          m_tx[k] = e.resp;
          if (!e.bad) m_cmd[k] = e.cmd;
          chk("cmd_valid_pop", k, 32'(cmd_valid[k]), 32'(!e.bad));
        end
      end else begin
        chk("cmd_valid_idle", k, 32'(cmd_valid[k]), 32'd0);
      end
      if (d) begin
        e = exp_of(k, (k == 0) ? 0 : 1, b, p);
        if (q[k].size() < depth_of(k)) q[k].push_back(e);
        else m_ovf[k] = 1'b1;
        if (e.bad && m_err[k] != 16'hFFFF) m_err[k] = m_err[k] + 16'd1;
      end
      chk("tx_data", k, 32'(tx_data[k]), 32'(m_tx[k]));
      chk("cmd_byte", k, 32'(cmd_byte[k]), 32'(m_cmd[k]));
      chk("fifo_level", k, 32'(lvl[k]), 32'(q[k].size()));
      chk("overflow", k, 32'(ovf[k]), 32'(m_ovf[k]));
      chk("err_count", k, 32'(errc[k]), 32'(m_err[k]));
    end
  endtask

  task automatic put_byte(input logic [7:0] b, input logic pe);
    rx_data = b; rx_perr = pe; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; rx_perr = 1'b0;
  endtask

  // Send one byte into an idle link and stop on the cycle tx_start must be high
  task automatic send_and_look(input logic [7:0] b, input logic pe);
    put_byte(b, pe);
    for (int k = 0; k < N; k++) chk("lat_one_edge", k, 32'(tx_start[k]), 32'd0);
    tick();
    for (int k = 0; k < N; k++) chk("lat_two_edges", k, 32'(tx_start[k]), 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0 || tx_busy != '0) && t < 400) begin
      tick();
      t++;
    end
    chk("drain_bound", 0, 32'(t < 400), 32'd1);
    repeat (8) tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int base[N];
    int gap, sel, i, j;
    logic [7:0] b;
    exp_t e;

    for (int k = 0; k < N; k++) begin
      n_starts[k] = 0; m_tx[k] = 0; m_cmd[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
    end

    // Model anchors against hand-decoded bytes
    e = exp_of(1, 1, 8'hC2, 1'b0);
    chk("model_single_err", 1, 32'({e.bad, e.resp, e.cmd}), 32'({1'b0, 8'h3C, 8'h0A}));
    e = exp_of(2, 1, 8'hE2, 1'b0);
    chk("model_double_err", 2, 32'({e.bad, e.resp}), 32'({1'b1, 8'hC3}));
    e = exp_of(2, 1, 8'h52, 1'b0);
    chk("model_b7_err", 2, 32'({e.bad, e.resp}), 32'({1'b0, 8'h0A}));

    repeat (3) tick();
    check_zero("reset_state");
    reset = 1'b0;
    tick();

    send_and_look(8'h9D, 1'b0);
    chk("echo_tx_data", 0, 32'(tx_data[0]), 32'h9D);
    chk("echo_cmd_valid", 0, 32'(cmd_valid[0]), 32'd1);
    chk("echo_cmd_byte", 0, 32'(cmd_byte[0]), 32'h9D);
    drain();

    pulse_reset();
    send_and_look(8'hD2, 1'b0);
    chk("ack_clean", 1, 32'(tx_data[1]), 32'h3C);
    chk("ack_clean_cmd", 1, 32'(cmd_byte[1]), 32'h0A);
    drain();
    send_and_look(8'hC2, 1'b0);
    chk("ack_corrected", 1, 32'(tx_data[1]), 32'h3C);
    chk("ack_corrected_cmd", 1, 32'(cmd_byte[1]), 32'h0A);
    chk("ack_err_zero", 1, 32'(errc[1]), 32'd0);
    drain();
    send_and_look(8'hD2, 1'b1);
    chk("nack_parity", 1, 32'(tx_data[1]), 32'hC3);
    chk("nack_parity_valid", 1, 32'(cmd_valid[1]), 32'd0);
    drain();

    pulse_reset();
    send_and_look(8'hE2, 1'b0);
    chk("dec_double", 2, 32'(tx_data[2]), 32'hC3);
    chk("dec_double_valid", 2, 32'(cmd_valid[2]), 32'd0);
    chk("dec_double_err", 2, 32'(errc[2]), 32'd1);
    drain();
    send_and_look(8'h52, 1'b0);
    chk("dec_b7", 2, 32'(tx_data[2]), 32'h0A);
    chk("dec_b7_valid", 2, 32'(cmd_valid[2]), 32'd1);
    drain();

    // Overflow with uart_tx stuck busy
    pulse_reset();
    for (int k = 0; k < N; k++) base[k] = n_starts[k];
    force_hi = 1'b1;
    for (int n = 0; n < 6; n++) put_byte(enc(4'(n + 3)), 1'b0);
    repeat (3) tick();
    chk("ovf_level", 1, 32'(lvl[1]), 32'd4);
    chk("ovf_flag", 1, 32'(ovf[1]), 32'd1);
    chk("ovf_level_deep", 0, 32'(lvl[0]), 32'd5);
    chk("ovf_flag_deep", 0, 32'(ovf[0]), 32'd0);
    force_hi = 1'b0;
    drain();
    chk("ovf_responses", 1, 32'(n_starts[1] - base[1]), 32'd5);
    chk("ovf_responses_deep", 0, 32'(n_starts[0] - base[0]), 32'd6);

    // uart_tx never acknowledges
    for (int k = 0; k < N; k++) base[k] = n_starts[k];
    no_resp = 1'b1;
    put_byte(8'hD2, 1'b0);
    put_byte(8'h33, 1'b0);
    drain();
    no_resp = 1'b0;
    for (int k = 0; k < N; k++) chk("timeout_responses", k, 32'(n_starts[k] - base[k]), 32'd2);

    // Reset while a response is in flight with three bytes queued
    force_hi = 1'b1;
    for (int n = 0; n < 4; n++) put_byte(enc(4'(n + 9)), 1'b0);
    repeat (3) tick();
    chk("pre_reset_level", 0, 32'(lvl[0]), 32'd3);
    #3;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    repeat (2) tick();
    reset = 1'b0;
    force_hi = 1'b0;
    for (int k = 0; k < N; k++) base[k] = n_starts[k];
    repeat (12) tick();
    for (int k = 0; k < N; k++) chk("no_reissue", k, 32'(n_starts[k] - base[k]), 32'd0);
    send_and_look(8'hD2, 1'b0);
    drain();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      gap = $urandom_range(0, 6);
      repeat (gap) tick();
      if ($urandom_range(0, 39) == 0) no_resp = ~no_resp;
      sel = $urandom_range(0, 3);
      b = enc(4'($urandom_range(0, 15)));
      if (sel == 1) b[$urandom_range(0, 7)] ^= 1'b1;
      else if (sel == 2) begin
        i = $urandom_range(0, 7);
        j = (i + 1 + $urandom_range(0, 6)) % 8;
        b[i] ^= 1'b1;
        b[j] ^= 1'b1;
      end else if (sel == 3) b = 8'($urandom());
      put_byte(b, ($urandom_range(0, 7) == 0));
    end
    no_resp = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_link.md
Name: uart_cmd_link

Overview:
Protocol layer between uart_rx and uart_tx for the FPGA link between the master and the FPGA_modulo boards. It accepts received bytes and optionally SECDED-decodes them as Hamming(7,4) plus overall parity. It buffers them in a FIFO and emits decoded commands. It sends one response byte per received byte: raw echo, ACK/NACK, or decoded echo.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
MODE, 0, response mode: 0 = raw echo, 1 = ACK/NACK, 2 = decoded echo
HAMMING, 1, 1 = decode rx byte as SECDED Hamming(7,4); 0 = pass the byte through
ACK_BYTE, 8'h3C, response for a good byte (MODE 1)
NACK_BYTE, 8'hC3, response for a bad byte (MODE 1, MODE 2)

Ports:
clk  in  1  system clock (48 MHz)
reset  in  1  asynchronous, active-high
rx_data  in  8  byte from uart_rx
rx_done  in  1  one-cycle strobe, rx_data valid
rx_parity_error  in  1  UART parity error, qualified by rx_done
tx_data  out  8  byte to uart_tx, held stable from tx_start until tx_busy falls
tx_start  out  1  one-cycle request to uart_tx
tx_busy  in  1  uart_tx busy
cmd_valid  out  1  one-cycle strobe, good command popped
cmd_byte  out  8  HAMMING=1: {4'h0,nibble}; HAMMING=0: raw byte
fifo_level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a byte was dropped; cleared only by reset
err_count  out  16  count of bad bytes, saturates at 16'hFFFF

Behaviour:
- Reset (asynchronous, active-high) sets every output and the internal state to 0, empties the FIFO and puts the FSM in IDLE. If reset occurs mid-transmit, tx_start is 0 and no response is re-issued afterwards.
- Hamming bit positions: b0=p1, b1=p2, b2=d0, b3=p3, b4=d1, b5=d2, b6=d3. b7 = overall even parity of b0..b7. nibble = {b6,b5,b4,b2}.
- Syndrome: s1=b0^b2^b4^b6, s2=b1^b2^b5^b6, s3=b3^b4^b5^b6. The 1-based erroneous position is {s3,s2,s1}. P = XOR of all 8 bits.
- syn=0, P=0: clean.
- syn!=0, P=1: single error; flip the bit at position syn and report the corrected nibble as good.
- syn=0, P=1: only b7 is in error; the byte is good.
- syn!=0, P=0: double error; the byte is bad.
- bad = rx_parity_error | double error. With HAMMING=0, bad = rx_parity_error.
- Decode is combinational on rx_data. On an rx_done edge, {bad, decoded byte, raw byte} is pushed into the FIFO.
- Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set.
- err_count increments on every rx_done with bad=1, including dropped bytes.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. fifo_level updates on the edge of each push/pop; a simultaneous push and pop leaves it unchanged.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: if the FIFO is not empty, pop, register tx_data per MODE, assert tx_start for one cycle, pulse cmd_valid if the entry is good, and go to START.
- START -> WAIT_BUSY unconditionally.
- WAIT_BUSY: go to WAIT_DONE when tx_busy=1. If tx_busy has not risen after 4 cycles, go to IDLE (lost request; no retry).
- WAIT_DONE: go to IDLE when tx_busy=0.
- tx_data by MODE:
  - MODE 0: raw byte, even when bad.
  - MODE 1: ACK_BYTE if good, else NACK_BYTE.
  - MODE 2: {4'h0,nibble} if good, else NACK_BYTE.
- Latency: with an empty FIFO and the FSM in IDLE, tx_start and cmd_valid are asserted in the cycle after the push edge, i.e. 2 edges after the rx_done cycle.
- Back-to-back bytes queue up while uart_tx is busy. Responses go out in arrival order.

Decomposition:
- Shared package/header (alongside UART.vh): MODE_ECHO/MODE_ACK/MODE_DECODED constants, default ACK/NACK codes, FSM state encodings.
- One combinational sub-module, hamm74_secded_dec: in [7:0]; outputs nibble[3:0], corrected, double_err.
- The FIFO stays inline.

Test Plan:
- MODE=0, HAMMING=0: rx_data=8'h9D with rx_done -> tx_start 2 edges later, tx_data=8'h9D, cmd_valid with cmd_byte=8'h9D.
- MODE=1, HAMMING=1: send 8'hD2 (clean 0xA), then 8'hC2 (b4 flipped) -> both give ACK 8'h3C and cmd_byte 8'h0A; err_count stays 0.
- MODE=2: send 8'hE2 (b4 and b5 flipped) -> tx_data=8'hC3, no cmd_valid, err_count=1. Send 8'h52 (b7 wrong) -> tx_data=8'h0A.
- DEPTH=4, tx_busy held high, 6 bytes sent -> fifo_level=4 (first byte popped: 1 in flight plus 4 stored, 1 dropped), overflow=1. Release tx_busy -> the 5 responses come out in arrival order.
- tx_busy never rises after tx_start -> FSM returns to IDLE after 4 cycles and the next queued byte is sent.
- reset asserted during WAIT_DONE with 3 entries queued -> outputs 0 immediately; after release no tx_start until a new rx_done arrives.
